// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: engine modes, CPU register map,
// controller states and the bounce direction.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   localparam logic [1:0] ADDR_MODE    = 2'd0;
   localparam logic [1:0] ADDR_PATTERN = 2'd1;
   localparam logic [1:0] ADDR_RATE    = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   typedef enum logic {
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   // True when exactly one bit of v is set.
   function automatic logic is_one_hot(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step timebase: a prescaler producing base ticks every CLK_DIV clocks and a
// rate counter producing one step pulse every RATE ticks (RATE=0 acts as 1).
module led_tick_gen #(
   parameter int CLK_DIV = 25000000,
   parameter int RATE_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [RATE_W-1:0] rate,
   output logic              step
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   logic [PRE_W-1:0]  pre_q,      pre_d;
   logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
   logic [RATE_W-1:0] rate_eff;
   logic              tick;
   logic              wrap;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      rate_eff   = (rate == '0) ? RATE_W'(1) : rate;
      tick       = en && (pre_q == PRE_LAST);
      wrap       = tick && (rate_cnt_q >= rate_eff - RATE_W'(1));
      pre_d      = pre_q;
      rate_cnt_d = rate_cnt_q;
      if (clr) begin
         pre_d      = '0;
         rate_cnt_d = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
         if (tick) begin
            rate_cnt_d = wrap ? '0 : rate_cnt_q + RATE_W'(1);
         end
      end
   end

   // A clear restarts the timebase, so a wrap coinciding with it is dropped.
   assign step = wrap && !clr;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q      <= '0;
         rate_cnt_q <= '0;
      end else begin
         pre_q      <= pre_d;
         rate_cnt_q <= rate_cnt_d;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED output controller: CPU register file plus a pattern engine that share
// the single write port (led_data/led_we) of the downstream LED register.
module led_sequencer
   import led_pkg::*;
#(
   parameter int CLK_DIV = 25000000,
   parameter int RATE_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_we,
   input  logic [1:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic [7:0] led_data,
   output logic       led_we
);

   state_e            state_q,   state_d;
   mode_e             mode_q,    mode_d;
   logic [7:0]        pattern_q, pattern_d;
   logic [RATE_W-1:0] rate_q,    rate_d;
   logic [7:0]        shadow_q,  shadow_d;
   dir_e              dir_q,     dir_d;
   logic              led_we_q,  led_we_d;

   logic  mode_wr, pat_wr, rate_wr, clr, step;
   mode_e new_mode;
   dir_e  bounce_dir;

   assign mode_wr  = cpu_we && (cpu_addr == ADDR_MODE);
   assign pat_wr   = cpu_we && (cpu_addr == ADDR_PATTERN);
   assign rate_wr  = cpu_we && (cpu_addr == ADDR_RATE);
   assign clr      = mode_wr || pat_wr || rate_wr;
   assign new_mode = mode_e'(cpu_wdata[1:0]);

   led_tick_gen #(
      .CLK_DIV (CLK_DIV),
      .RATE_W  (RATE_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (mode_q != MODE_MANUAL),
      .rate (rate_q),
      .step (step)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      pattern_d  = pattern_q;
      rate_d     = rate_q;
      shadow_d   = shadow_q;
      dir_d      = dir_q;
      led_we_d   = 1'b0;
      bounce_dir = dir_q;

      if (mode_wr) mode_d    = new_mode;
      if (pat_wr)  pattern_d = cpu_wdata;
      if (rate_wr) rate_d    = RATE_W'(cpu_wdata);

      case (state_q)
         // The LED register powers up unknown, so the first cycle clears it.
         ST_INIT: begin
            shadow_d = 8'h00;
            led_we_d = 1'b1;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            if (pat_wr) begin
               shadow_d = cpu_wdata;
               led_we_d = 1'b1;
            end else if (mode_wr && (new_mode != mode_q)) begin
               shadow_d = pattern_q;
               dir_d    = DIR_LEFT;
               led_we_d = 1'b1;
            end else if (step) begin
               led_we_d = (mode_q != MODE_MANUAL);
               case (mode_q)
                  MODE_BLINK:  shadow_d = (shadow_q != 8'h00) ? 8'h00 : pattern_q;
                  MODE_ROTATE: shadow_d = {shadow_q[6:0], shadow_q[7]};
                  MODE_BOUNCE: begin
                     if (!is_one_hot(shadow_q)) begin
                        shadow_d = 8'h01;
                        dir_d    = DIR_LEFT;
                     end else begin
                        // The end bits force the direction, so a pattern
                        // loaded at either end never shifts out.
                        if (shadow_q[7])      bounce_dir = DIR_RIGHT;
                        else if (shadow_q[0]) bounce_dir = DIR_LEFT;
                        dir_d    = bounce_dir;
                        shadow_d = (bounce_dir == DIR_LEFT) ? (shadow_q << 1)
                                                            : (shadow_q >> 1);
                     end
                  end
                  default: shadow_d = shadow_q;
               endcase
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         mode_q    <= MODE_MANUAL;
         pattern_q <= 8'h00;
         rate_q    <= RATE_W'(1);
         shadow_q  <= 8'h00;
         dir_q     <= DIR_LEFT;
         led_we_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         pattern_q <= pattern_d;
         rate_q    <= rate_d;
         shadow_q  <= shadow_d;
         dir_q     <= dir_d;
         led_we_q  <= led_we_d;
      end
   end

   always_comb begin
      cpu_rdata = 8'h00;
      case (cpu_addr)
         ADDR_MODE:    cpu_rdata = {6'b0, mode_q};
         ADDR_PATTERN: cpu_rdata = pattern_q;
         ADDR_RATE:    cpu_rdata = 8'(rate_q);
         default:      cpu_rdata = shadow_q;
      endcase
   end

   assign led_data = shadow_q;
   assign led_we   = led_we_q;

endmodule
